sound_event_queue: RTL and testbench
====================================

SOUND_EVENT_QUEUE -- requirements
Module: sound_event_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue capacity in entries; power of two, minimum 2.
REQ-002 Parameter GAP_CYCLES, default 5000000, silent clocks between successive sounds; 0 is legal.
REQ-003 Parameter ACK_TIMEOUT, default 8, clocks to wait for the player's busy flag after a play request.
REQ-004 clk  input  1  system clock; all state on its rising edge.
REQ-005 rst  input  1  reset; the block has one clock, and reset is asynchronous and active-high.
REQ-006 evt  input  7  single-cycle sound requests; bit i-1 requests sound code i (1 select, 2 cancel, 3 move, 4 capture, 5 illegal, 6 promotion, 7 game over).
REQ-007 snd_busy  input  1  player busy flag; high while a sound is playing.
REQ-008 sound_code  output  3  code of the most recently issued sound, registered.
REQ-009 play_sound  output  1  one-clock play request to the player, registered.
REQ-010 q_level  output  $clog2(DEPTH)+1  current queue occupancy.
REQ-011 overflow  output  1  sticky flag; set when a request is lost to a full queue.
REQ-012 drop_cnt  output  8  saturating count of clocks in which at least one request was discarded.

Function
REQ-013 The block SHALL accept at most one request per clock: the highest set bit of evt wins, and any lower set bits are discarded.
REQ-014 A clock in which more than one evt bit is set SHALL increment drop_cnt by 1.
REQ-015 drop_cnt SHALL saturate at 255.
REQ-016 The winning code SHALL be discarded, without incrementing drop_cnt, when it equals the tail entry of a non-empty queue (de-duplication).
REQ-017 When the winning code is 7, the queue SHALL be flushed and left holding only code 7, regardless of fill level, and overflow SHALL NOT be set.
REQ-018 A sound already in flight (ISSUE, ACK, PLAY or GAP) SHALL NOT be aborted by a flush.
REQ-019 A code other than 7 arriving at a full queue, with no pop in the same clock, SHALL be discarded, SHALL set overflow and SHALL increment drop_cnt.
REQ-020 An enqueue and a pop in the same clock on a full queue SHALL both succeed, leaving q_level unchanged.
REQ-021 The queue SHALL be a circular FIFO, with read and write pointers wrapping modulo DEPTH.
REQ-022 The dispatch FSM SHALL have five states: IDLE, ISSUE, ACK, PLAY and GAP.
REQ-023 In IDLE, when q_level>0 and snd_busy=0, the FSM SHALL pop the head entry into sound_code and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-024 play_sound SHALL be high exactly while the FSM is in ISSUE, which lasts one clock; ISSUE then goes to ACK.
REQ-025 In ACK, snd_busy=1 SHALL move the FSM to PLAY; after ACK_TIMEOUT clocks without busy, the FSM SHALL go to GAP with no retry.
REQ-026 In PLAY, snd_busy=0 SHALL move the FSM to GAP.
REQ-027 GAP SHALL last GAP_CYCLES clocks and then go to IDLE; with GAP_CYCLES=0, GAP SHALL go to IDLE on the next clock.
REQ-028 Latency, with the queue empty and the FSM in IDLE: for evt sampled at edge n, q_level=1 after edge n and play_sound is high for the clock between edges n+1 and n+2.
REQ-029 The queue SHALL NOT be bypassed.
REQ-030 sound_code SHALL hold its value until the next pop.
REQ-031 overflow SHALL clear only on reset.

Reset
REQ-032 While rst is high, the block SHALL hold: FSM in IDLE, queue empty, q_level=0, sound_code=0, play_sound=0, overflow=0, drop_cnt=0, timers=0.
REQ-033 Asserting rst mid-sound SHALL clear the block immediately, with no play_sound glitch.
REQ-034 The first request SHALL be accepted on the first rising edge after rst is released.

Verification
REQ-035 Single request: GAP_CYCLES=4; evt=7'b0000100 at edge 0 with snd_busy modelled as high 1 clock after play_sound for 3 clocks -> play_sound high in the clock between edges 1 and 2, sound_code=3; FSM goes IDLE, ISSUE, ACK, PLAY, GAP and returns to IDLE after 4 gap clocks.
REQ-036 Simultaneous requests: evt=7'b0011001 -> only code 5 is enqueued; drop_cnt=1.
REQ-037 Overflow: with DEPTH=4, stall the player and enqueue 1, 2, 3, 4, 6 -> q_level=4, overflow=1, drop_cnt=1; codes issue in order 1, 2, 3, 4.
REQ-038 De-duplication and flush: enqueue 3 then 3 -> q_level=1, drop_cnt=0; with 1, 2, 4 queued, evt code 7 -> q_level=1 and the next issued code is 7.
REQ-039 Ack timeout: snd_busy held low after play_sound -> ACK_TIMEOUT=8 clocks in ACK, then GAP, then the next entry is issued.
REQ-040 Reset mid-play: assert rst during PLAY with 2 entries queued -> all outputs 0 within the same clock, and no play_sound after rst is released.

Source files
------------

// File: rtl/sound_event_queue.sv
// Sound request queue and dispatcher: prioritises and de-duplicates event requests,
// buffers them in a circular FIFO and paces play requests to an external sound player.
module sound_event_queue #(
  parameter int DEPTH       = 4,
  parameter int GAP_CYCLES  = 5000000,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [6:0]               evt,
  input  logic                     snd_busy,
  output logic [2:0]               sound_code,
  output logic                     play_sound,
  output logic [$clog2(DEPTH):0]   q_level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXC = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] ACK_LAST = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ACK, S_PLAY, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      code_q, code_d;
  logic            play_q, play_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      drop_q, drop_d;
  logic [2:0]      mem_q [DEPTH];
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]     level_q, level_d;
  logic [2:0]      tail_q, tail_d;

  logic [2:0]      win_code;
  logic            multi_evt, flush, dup, full, pop, push, lost;

  always_comb begin
    win_code = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (evt[i]) win_code = 3'(i + 1);
    end
  end

  assign multi_evt = (evt & (evt - 7'd1)) != 7'd0;
  assign flush     = (win_code == 3'd7);
  assign dup       = (level_q != '0) && (win_code == tail_q);
  assign full      = (level_q == (AW+1)'(DEPTH));
  assign pop       = (state_q == S_IDLE) && (level_q != '0) && !snd_busy;

  always_comb begin
    push = 1'b0;
    lost = 1'b0;
    if (win_code != 3'd0 && !flush && !dup) begin
      if (full && !pop) lost = 1'b1;
      else              push = 1'b1;
    end
  end

  // A flush rewrites the queue as a single entry at the current write slot,
  // so a head popped in the same clock is still read from the old contents.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    level_d = level_q;
    tail_d  = tail_q;
    if (flush) begin
      rd_d    = wr_q;
      wr_d    = wr_q + AW'(1);
      level_d = (AW+1)'(1);
      tail_d  = 3'd7;
    end else begin
      if (push) begin
        wr_d   = wr_q + AW'(1);
        tail_d = win_code;
      end
      if (pop) rd_d = rd_q + AW'(1);
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push || flush) mem_q[wr_q] <= flush ? 3'd7 : win_code;
  end

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_ISSUE;
          code_d  = mem_q[rd_q];
        end
      end
      S_ISSUE: state_d = S_ACK;
      S_ACK: begin
        if (snd_busy)                state_d = S_PLAY;
        else if (timer_q == ACK_LAST) state_d = S_GAP;
        else                         timer_d = timer_q + TW'(1);
      end
      S_PLAY: begin
        if (!snd_busy) state_d = S_GAP;
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) state_d = S_IDLE;
        else                     timer_d = timer_q + TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    play_d = (state_d == S_ISSUE);
    ovf_d  = ovf_q | lost;
    drop_d = ((multi_evt || lost) && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      code_q  <= 3'd0;
      play_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 8'd0;
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
      tail_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      code_q  <= code_d;
      play_q  <= play_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
      tail_q  <= tail_d;
    end
  end

  assign sound_code = code_q;
  assign play_sound = play_q;
  assign q_level    = level_q;
  assign overflow   = ovf_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_sound_event_queue.sv
// Directed bench for sound_event_queue (DEPTH=4, GAP_CYCLES=4, ACK_TIMEOUT=8) with a
// simple player model: 0 = never busy, 1 = busy 3 clocks one clock after play, 2 = stalled.
module tb_sound_event_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] evt = 7'd0;
  logic       snd_busy;
  logic [2:0] sound_code;
  logic       play_sound;
  logic [2:0] q_level;
  logic       overflow;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int player_mode = 0;
  int busy_left = 0;
  logic [2:0] play_codes[$];

  sound_event_queue #(.DEPTH(4), .GAP_CYCLES(4), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .evt(evt), .snd_busy(snd_busy),
    .sound_code(sound_code), .play_sound(play_sound), .q_level(q_level),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    snd_busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (player_mode == 2) begin
        snd_busy = 1'b1; busy_left = 0;
      end else if (player_mode == 0) begin
        snd_busy = 1'b0; busy_left = 0;
      end else begin
        if (busy_left > 0) begin snd_busy = 1'b1; busy_left--; end
        else snd_busy = 1'b0;
        if (play_sound) busy_left = 3;
      end
    end
  end

  always @(negedge clk) begin
    if (play_sound) play_codes.push_back(sound_code);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [6:0] v);
    evt = v; tick(); evt = 7'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1; evt = 7'd0; tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    checks++; if (sound_code !== 3'd0) begin errors++; $display("FAIL reset_code got %0d want 0", sound_code); end
    checks++; if (play_sound !== 1'b0) begin errors++; $display("FAIL reset_play got %0d want 0", play_sound); end
    checks++; if (q_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", q_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0d want 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    player_mode = 1; do_reset(); play_codes.delete();
    send(7'b0000100);
    checks++; if (q_level !== 3'd1) begin errors++; $display("FAIL single_level got %0d want 1", q_level); end
    checks++; if (play_sound !== 1'b0) begin errors++; $display("FAIL single_early_play got %0d want 0", play_sound); end
    tick();
    checks++; if (play_sound !== 1'b1) begin errors++; $display("FAIL single_play got %0d want 1", play_sound); end
    checks++; if (sound_code !== 3'd3) begin errors++; $display("FAIL single_code got %0d want 3", sound_code); end
    tick();
    checks++; if (play_sound !== 1'b0) begin errors++; $display("FAIL single_play_len got %0d want 0", play_sound); end
    send(7'b0000001);
    checks++; if (q_level !== 3'd1) begin errors++; $display("FAIL single_level2 got %0d want 1", q_level); end
    repeat (7) tick();
    checks++; if (play_sound !== 1'b0) begin errors++; $display("FAIL single_gap_play got %0d want 0", play_sound); end
    tick();
    checks++; if (play_sound !== 1'b1) begin errors++; $display("FAIL single_next_play got %0d want 1", play_sound); end
    checks++; if (sound_code !== 3'd1) begin errors++; $display("FAIL single_next_code got %0d want 1", sound_code); end
    repeat (14) tick();
    checks++; if (play_codes.size() != 2) begin errors++; $display("FAIL single_plays got %0d want 2", play_codes.size()); end
    $display("test_single done");
  endtask

  task automatic test_simultaneous();
    player_mode = 2; do_reset();
    send(7'b0011001);
    checks++; if (q_level !== 3'd1) begin errors++; $display("FAIL simul_level got %0d want 1", q_level); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL simul_drop got %0d want 1", drop_cnt); end
    play_codes.delete(); player_mode = 1; tick();
    checks++; if (play_sound !== 1'b1) begin errors++; $display("FAIL simul_play got %0d want 1", play_sound); end
    checks++; if (sound_code !== 3'd5) begin errors++; $display("FAIL simul_code got %0d want 5", sound_code); end
    repeat (14) tick();
    checks++; if (play_codes.size() != 1) begin errors++; $display("FAIL simul_plays got %0d want 1", play_codes.size()); end
    $display("test_simultaneous done");
  endtask

  task automatic test_overflow();
    player_mode = 2; do_reset();
    send(7'b0000001); send(7'b0000010); send(7'b0000100); send(7'b0001000); send(7'b0100000);
    checks++; if (q_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", q_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0d want 1", overflow); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL ovf_drop got %0d want 1", drop_cnt); end
    play_codes.delete(); player_mode = 0;
    send(7'b0010000);
    checks++; if (q_level !== 3'd4) begin errors++; $display("FAIL full_pushpop_level got %0d want 4", q_level); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL full_pushpop_drop got %0d want 1", drop_cnt); end
    checks++; if (sound_code !== 3'd1) begin errors++; $display("FAIL full_pushpop_code got %0d want 1", sound_code); end
    repeat (70) tick();
    checks++; if (play_codes.size() != 5) begin errors++; $display("FAIL ovf_plays got %0d want 5", play_codes.size()); end
    for (int i = 0; i < 5; i++) begin
      logic [2:0] exp_c;
      logic [2:0] got_c;
      exp_c = 3'(i + 1);
      got_c = (play_codes.size() > i) ? play_codes[i] : 3'd0;
      checks++; if (got_c !== exp_c) begin errors++; $display("FAIL ovf_order[%0d] got %0d want %0d", i, got_c, exp_c); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0d want 1", overflow); end
    $display("test_overflow done");
  endtask

  task automatic test_dedup_flush();
    player_mode = 2; do_reset();
    send(7'b0000100); send(7'b0000100);
    checks++; if (q_level !== 3'd1) begin errors++; $display("FAIL dedup_level got %0d want 1", q_level); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL dedup_drop got %0d want 0", drop_cnt); end
    do_reset();
    send(7'b0000001); send(7'b0000010); send(7'b0001000);
    checks++; if (q_level !== 3'd3) begin errors++; $display("FAIL flush_prelevel got %0d want 3", q_level); end
    send(7'b1000000);
    checks++; if (q_level !== 3'd1) begin errors++; $display("FAIL flush_level got %0d want 1", q_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf got %0d want 0", overflow); end
    play_codes.delete(); player_mode = 1; tick();
    checks++; if (play_sound !== 1'b1) begin errors++; $display("FAIL flush_play got %0d want 1", play_sound); end
    checks++; if (sound_code !== 3'd7) begin errors++; $display("FAIL flush_code got %0d want 7", sound_code); end
    repeat (14) tick();
    checks++; if (play_codes.size() != 1) begin errors++; $display("FAIL flush_plays got %0d want 1", play_codes.size()); end
    $display("test_dedup_flush done");
  endtask

  task automatic test_ack_timeout();
    player_mode = 0; do_reset();
    send(7'b0000010);
    send(7'b0100000);
    checks++; if (play_sound !== 1'b1) begin errors++; $display("FAIL ack_first_play got %0d want 1", play_sound); end
    repeat (13) tick();
    checks++; if (play_sound !== 1'b0) begin errors++; $display("FAIL ack_wait_play got %0d want 0", play_sound); end
    checks++; if (sound_code !== 3'd2) begin errors++; $display("FAIL ack_hold_code got %0d want 2", sound_code); end
    checks++; if (q_level !== 3'd1) begin errors++; $display("FAIL ack_level got %0d want 1", q_level); end
    tick();
    checks++; if (play_sound !== 1'b1) begin errors++; $display("FAIL ack_next_play got %0d want 1", play_sound); end
    checks++; if (sound_code !== 3'd6) begin errors++; $display("FAIL ack_next_code got %0d want 6", sound_code); end
    repeat (16) tick();
    $display("test_ack_timeout done");
  endtask

  task automatic test_reset_mid_play();
    player_mode = 1; do_reset();
    send(7'b0000011); send(7'b0000001); send(7'b0001000);
    tick();
    checks++; if (q_level !== 3'd2) begin errors++; $display("FAIL midrst_prelevel got %0d want 2", q_level); end
    checks++; if (sound_code !== 3'd2) begin errors++; $display("FAIL midrst_precode got %0d want 2", sound_code); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL midrst_predrop got %0d want 1", drop_cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if (sound_code !== 3'd0) begin errors++; $display("FAIL midrst_code got %0d want 0", sound_code); end
    checks++; if (play_sound !== 1'b0) begin errors++; $display("FAIL midrst_play got %0d want 0", play_sound); end
    checks++; if (q_level !== 3'd0) begin errors++; $display("FAIL midrst_level got %0d want 0", q_level); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL midrst_drop got %0d want 0", drop_cnt); end
    tick(); tick(); rst = 1'b0; play_codes.delete();
    repeat (20) tick();
    checks++; if (play_codes.size() != 0) begin errors++; $display("FAIL midrst_plays got %0d want 0", play_codes.size()); end
    $display("test_reset_mid_play done");
  endtask

  task automatic test_drop_saturation();
    player_mode = 2; do_reset();
    repeat (255) send(7'b0000011);
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop255 got %0d want 255", drop_cnt); end
    repeat (5) send(7'b0000011);
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop_hold got %0d want 255", drop_cnt); end
    checks++; if (q_level !== 3'd1) begin errors++; $display("FAIL sat_level got %0d want 1", q_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sat_ovf got %0d want 0", overflow); end
    $display("test_drop_saturation done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overflow();
    test_dedup_flush();
    test_ack_timeout();
    test_reset_mid_play();
    test_drop_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
